// File: rtl/lsu_bus_ctrl_if.sv
// lsu_bus_ctrl_if
// Data-memory bus between the load/store unit (master) and a
// variable-latency data memory (slave).
//   bus_req   master->slave  request valid, held until ack or abort
//   bus_we    master->slave  1 = write
//   bus_be    master->slave  byte enables, be[0] = byte 0 (little-endian)
//   bus_addr  master->slave  word-aligned byte address
//   bus_wdata master->slave  store data, replicated to lanes
//   bus_rdata slave->master  read word, valid with bus_ack
//   bus_ack   slave->master  single-cycle completion pulse
interface lsu_bus_ctrl_if #(
  parameter int AW = 32
);
  logic          bus_req;
  logic          bus_we;
  logic [3:0]    bus_be;
  logic [AW-1:0] bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ack;

  modport master (
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
// Load/store unit between the decoder/ALU and the data-memory bus. Decodes
// MemWrite/LAddr, checks alignment, runs a req/ack handshake with a timeout
// and returns sign/zero-extended load data.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   mem_read          load in execute (WDSel[0])
//   MemWrite[1:0]     00 none, 01 sw, 10 sb, 11 sh
//   LAddr[2:0]        000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, else lw
//   addr, wdata       effective address and store data
//   rdata             extended load result
//   stall             freeze PC/regfile while an access is in flight
//   misalign, bus_err one-cycle status pulses
//   bus               master side of lsu_bus_ctrl_if
module lsu_bus_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic [1:0]    MemWrite,
  input  logic [2:0]    LAddr,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic          misalign,
  output logic          bus_err,
  lsu_bus_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          is_write, access, aligned, start;
  logic [1:0]    size;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;
  logic [31:0]   ext_data;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          bus_req_c;

  logic          we_q;
  logic [3:0]    be_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    lat_off;
  logic [2:0]    lat_type;
  logic          lat_read;

  assign bus.bus_req   = bus_req_c;
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  // Access decode. size: 0 = byte, 1 = half, 2 = word. A write overrides
  // a simultaneous read.
  always_comb begin
    is_write = (MemWrite != 2'b00);
    access   = mem_read | is_write;
    size     = 2'd2;
    if (is_write) begin
      case (MemWrite)
        2'b10:   size = 2'd0;
        2'b11:   size = 2'd1;
        default: size = 2'd2;
      endcase
    end else begin
      case (LAddr)
        3'b001, 3'b010: size = 2'd0;
        3'b011, 3'b100: size = 2'd1;
        default:        size = 2'd2;
      endcase
    end

    aligned   = 1'b1;
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    case (size)
      2'd0: begin
        be_nxt    = 4'b0001 << addr[1:0];
        wdata_nxt = {4{wdata[7:0]}};
      end
      2'd1: begin
        aligned   = ~addr[0];
        be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{wdata[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Lane selection uses the offset latched at issue, not the live address.
  always_comb begin
    byte_sel = bus.bus_rdata[{lat_off, 3'b000} +: 8];
    half_sel = lat_off[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (lat_type)
      3'b001:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  ext_data = {24'h0, byte_sel};
      3'b011:  ext_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_data = {16'h0, half_sel};
      default: ext_data = bus.bus_rdata;
    endcase
  end

  // Next state and status outputs. Reset masks everything so bus_req and
  // stall drop in the same cycle rst is raised.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    misalign  = 1'b0;
    bus_err   = 1'b0;
    bus_req_c = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            stall     = 1'b1;
            start     = 1'b1;
            state_nxt = REQ;
          end else begin
            misalign = 1'b1;
          end
        end
      end
      REQ: begin
        stall     = 1'b1;
        bus_req_c = 1'b1;
        if (bus.bus_ack) begin
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          bus_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt = IDLE;
      stall     = 1'b0;
      misalign  = 1'b0;
      bus_err   = 1'b0;
      bus_req_c = 1'b0;
      start     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      lat_off  <= 2'b00;
      lat_type <= 3'b000;
      lat_read <= 1'b0;
      rdata    <= 32'h0;
    end else begin
      state <= state_nxt;
      if (start) begin
        we_q     <= is_write;
        be_q     <= be_nxt;
        addr_q   <= {addr[AW-1:2], 2'b00};
        wdata_q  <= wdata_nxt;
        lat_off  <= addr[1:0];
        lat_type <= LAddr;
        lat_read <= ~is_write;
        cnt      <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (state == REQ) begin
        if (bus.bus_ack) begin
          if (lat_read) rdata <= ext_data;
        end else if (cnt == CNT_LAST) begin
          rdata <= 32'h0;
        end
      end
    end
  end

endmodule
